// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, FSM state
// encodings and the ALU opcode map.
package alu_arb_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned OP_W_DEF   = 4;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_CAPT = 2'd2;

    // ALU opcode map; the arbiter forwards every opcode unmodified
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_XNOR = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_SUB  = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_DEC  = 4'hD;
    localparam logic [3:0] OP_ROL  = 4'hE;
    localparam logic [3:0] OP_ROR  = 4'hF;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way request arbiter. Default build is round-robin with a last-grant
// register (reset to requester 1 so requester 0 wins the first tie).
// Defining ALU_ARB_FIXED_PRIO_EN selects fixed priority to requester 0.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // No state is kept in fixed-priority mode
    logic unused_ok;
    assign unused_ok = ^{clk, rst, update};

    // Requester 0 always wins a tie
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end
`else
    logic last_q; // 1: requester 1 was granted last

    // Remember who won the most recent accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= gnt[1];
        end
    end

    // On a tie, favour the requester that was not granted last
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters. Each operation walks
// IDLE -> EXEC -> CAPT -> IDLE, giving one operation per three cycles.
// Tie-break policy is set by ALU_ARB_FIXED_PRIO_EN (see alu_rr_arb2).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_ovf,
    output logic              rsp0_udf,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_ovf,
    output logic              rsp1_udf,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    input  logic              alu_udf,
    output logic              busy,
    output logic [7:0]        ops_done
);

    state_t     state_q, state_d;
    logic       owner_q; // requester that owns the in-flight operation
    logic [1:0] gnt;
    logic       idle;
    logic       accept;

    alu_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .update (accept),
        .gnt    (gnt)
    );

    assign idle       = (state_q == ST_IDLE);
    assign req0_ready = idle & ~rst & gnt[0];
    assign req1_ready = idle & ~rst & gnt[1];
    assign accept     = req0_ready | req1_ready;
    assign busy       = ~idle;

    // Next-state: accept leaves IDLE, then two fixed steps back to IDLE
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU issue: opcode is live only for the EXEC cycle, NOP otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op  <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            owner_q <= 1'b0;
        end else if (accept) begin
            alu_op  <= gnt[1] ? req1_op : req0_op;
            alu_in1 <= gnt[1] ? req1_a  : req0_a;
            alu_in2 <= gnt[1] ? req1_b  : req0_b;
            owner_q <= gnt[1];
        end else begin
            alu_op  <= '0;
        end
    end

    // Capture ALU result into the owner's response slot on leaving CAPT
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_ovf    <= 1'b0;
            rsp0_udf    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_ovf    <= 1'b0;
            rsp1_udf    <= 1'b0;
            ops_done    <= 8'd0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (state_q == ST_CAPT) begin
                ops_done <= ops_done + 8'd1;
                if (owner_q) begin
                    rsp1_valid  <= 1'b1;
                    rsp1_result <= alu_result;
                    rsp1_ovf    <= alu_ovf;
                    rsp1_udf    <= alu_udf;
                end else begin
                    rsp0_valid  <= 1'b1;
                    rsp0_result <= alu_result;
                    rsp0_ovf    <= alu_ovf;
                    rsp0_udf    <= alu_udf;
                end
            end
        end
    end

endmodule
